// File: rtl/seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_checker                                                |
// | Description : Serial sequence lock checker. Shifts valid serial bits     |
// |               into a 4-bit history register, predicts the next bit       |
// |               from the history with one of four selectable functions,    |
// |               and runs a FILL -> SYNC -> LOCKED state machine that       |
// |               declares lock after 8 consecutive correct predictions and  |
// |               drops it after 3 consecutive mispredictions.               |
// |                                                                          |
// | Ports       : clk       - clock, rising edge                             |
// |               rst       - asynchronous reset, active-high                |
// |               C         - sequence select (0..3)                         |
// |               din       - received serial bit                            |
// |               din_valid - din qualifier; all state holds when low        |
// |               lock      - registered, high while in LOCKED               |
// |               err       - one-cycle pulse on a mismatched bit in LOCKED  |
// |               err_cnt   - saturating locked-mismatch count               |
// |               R         - current 4-bit history register                 |
// |                                                                          |
// | Build macro : SEQ_CHECKER_ERR_CNT_EN - when defined, err_cnt counts      |
// |               locked mismatches; otherwise err_cnt is tied to zero.      |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] C,
    input  logic       din,
    input  logic       din_valid,
    output logic       lock,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [3:0] R
);

    localparam logic [1:0] c_stFill   = 2'd0;
    localparam logic [1:0] c_stSync   = 2'd1;
    localparam logic [1:0] c_stLocked = 2'd2;

    localparam logic [1:0] c_fillLast  = 2'd3;  // 4th fill bit
    localparam logic [2:0] c_matchLast = 3'd7;  // 8th consecutive match
    localparam logic [1:0] c_missLast  = 2'd2;  // 3rd consecutive miss

    logic [1:0] r_state;
    logic [1:0] r_fillCnt;
    logic [2:0] r_matchCnt;
    logic [1:0] r_missCnt;
    logic [1:0] r_cPrev;
    logic [3:0] r_hist;
    logic       r_lock;

    logic       w_pred;
    logic       w_cChange;
    logic       w_mismatch;
    logic       w_err;

    // Predicted next bit for the currently selected sequence.
    always_comb begin
        w_pred = 1'b0;
        case (C)
            2'd0: w_pred = ~(r_hist[0] | r_hist[1] | r_hist[2]);
            2'd1: w_pred = ~r_hist[3] |
                           (r_hist[3] & ~r_hist[2] & ~r_hist[1] & r_hist[0]);
            2'd2: w_pred = ~r_hist[3] |
                           (r_hist[3] & r_hist[2] & ~r_hist[1] & ~r_hist[0]);
            2'd3: w_pred = (r_hist[0] ^ r_hist[3]) | (r_hist == 4'b0000);
            default: w_pred = 1'b0;
        endcase
    end

    assign w_cChange  = (C != r_cPrev);
    assign w_mismatch = (din != w_pred);

    // err is a Mealy pulse qualified by din_valid so it is low on idle
    // cycles. A bit arriving with a sequence change is a fill bit, not a
    // locked comparison, so the change masks it.
    assign w_err = din_valid & ~w_cChange & (r_state == c_stLocked) & w_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_stFill;
            r_fillCnt  <= 2'd0;
            r_matchCnt <= 3'd0;
            r_missCnt  <= 2'd0;
            r_cPrev    <= C;     // no spurious change seen right after reset
            r_hist     <= 4'b0000;
            r_lock     <= 1'b0;
        end else begin
            r_cPrev <= C;

            // History always shifts on a valid bit, including on a C change.
            if (din_valid) begin
                r_hist <= {r_hist[2:0], din};
            end

            if (w_cChange) begin
                // Restart acquisition; a coincident valid bit is fill bit 1.
                r_state    <= c_stFill;
                r_fillCnt  <= din_valid ? 2'd1 : 2'd0;
                r_matchCnt <= 3'd0;
                r_missCnt  <= 2'd0;
                r_lock     <= 1'b0;
            end else if (din_valid) begin
                case (r_state)
                    c_stFill: begin
                        if (r_fillCnt == c_fillLast) begin
                            r_state    <= c_stSync;
                            r_fillCnt  <= 2'd0;
                            r_matchCnt <= 3'd0;
                        end else begin
                            r_fillCnt <= r_fillCnt + 2'd1;
                        end
                    end
                    c_stSync: begin
                        if (w_mismatch) begin
                            r_matchCnt <= 3'd0;
                        end else if (r_matchCnt == c_matchLast) begin
                            r_state    <= c_stLocked;
                            r_matchCnt <= 3'd0;
                            r_missCnt  <= 2'd0;
                            r_lock     <= 1'b1;
                        end else begin
                            r_matchCnt <= r_matchCnt + 3'd1;
                        end
                    end
                    c_stLocked: begin
                        if (w_mismatch) begin
                            if (r_missCnt == c_missLast) begin
                                r_state    <= c_stSync;
                                r_matchCnt <= 3'd0;
                                r_missCnt  <= 2'd0;
                                r_lock     <= 1'b0;
                            end else begin
                                r_missCnt <= r_missCnt + 2'd1;
                            end
                        end else begin
                            r_missCnt <= 2'd0;
                        end
                    end
                    default: begin
                        // Unused encoding: recover through FILL.
                        r_state    <= c_stFill;
                        r_fillCnt  <= 2'd0;
                        r_matchCnt <= 3'd0;
                        r_missCnt  <= 2'd0;
                        r_lock     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_CHECKER_ERR_CNT_EN
    logic [7:0] r_errCnt;

    // Saturates at 255; a C change leaves the count untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errCnt <= 8'd0;
        end else if (w_err && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

    assign err_cnt = r_errCnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign lock = r_lock;
    assign err  = w_err;
    assign R    = r_hist;

endmodule
`default_nettype wire

// File: tb/tb_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seq_checker                                             |
// | Description : Directed self-checking bench for seq_checker. Expected     |
// |               err_cnt values follow SEQ_CHECKER_ERR_CNT_EN.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seq_checker;

`ifdef SEQ_CHECKER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] C;
    logic       din;
    logic       din_valid;
    logic       lock;
    logic       err;
    logic [7:0] err_cnt;
    logic [3:0] R;

    int   passCnt = 0;
    int   totalCnt = 0;
    int   errSeen = 0;
    int   errBase;
    logic lastErr;
    logic [3:0] rModel;

    seq_checker dut (
        .clk       (clk),
        .rst       (rst),
        .C         (C),
        .din       (din),
        .din_valid (din_valid),
        .lock      (lock),
        .err       (err),
        .err_cnt   (err_cnt),
        .R         (R)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic predict(input logic [1:0] c, input logic [3:0] r);
        case (c)
            2'd0:    return ~(r[0] | r[1] | r[2]);
            2'd1:    return ~r[3] | (r[3] & ~r[2] & ~r[1] & r[0]);
            2'd2:    return ~r[3] | (r[3] & r[2] & ~r[1] & ~r[0]);
            default: return (r[0] ^ r[3]) | (r == 4'b0000);
        endcase
    endfunction

    function automatic logic [7:0] expCnt(input int n);
        return CNT_EN ? n[7:0] : 8'd0;
    endfunction

    // Inputs change 1 time unit after a rising edge; err is sampled at the
    // falling edge, registered outputs 1 unit after the next rising edge.
    task automatic step(input logic v, input logic b);
        din_valid = v;
        din = b;
        @(negedge clk);
        lastErr = err;
        if (err === 1'b1) errSeen++;
        @(posedge clk);
        #1;
        if (v) rModel = {rModel[2:0], b};
    endtask

    task automatic sendGood();
        step(1'b1, predict(C, rModel));
    endtask

    task automatic sendBad();
        step(1'b1, ~predict(C, rModel));
    endtask

    task automatic test_reset();
        rst = 1'b1; C = 2'd0; din = 1'b0; din_valid = 1'b0; rModel = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        totalCnt++; if (lock !== 1'b0) $display("FAIL reset_lock: got %b expected 0", lock); else passCnt++;
        totalCnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passCnt++;
        totalCnt++; if (err_cnt !== 8'd0) $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); else passCnt++;
        totalCnt++; if (R !== 4'b0000) $display("FAIL reset_R: got %b expected 0000", R); else passCnt++;
        rst = 1'b0;
    endtask

    task automatic test_lock();
        logic [3:0] pat;
        pat = 4'b1000;
        errBase = errSeen;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, pat[3 - (i % 4)]);
            if (i == 10) begin
                totalCnt++; if (lock !== 1'b0) $display("FAIL lock_early_11: got %b expected 0", lock); else passCnt++;
            end
        end
        totalCnt++; if (lock !== 1'b1) $display("FAIL lock_at_12: got %b expected 1", lock); else passCnt++;
        totalCnt++; if (errSeen - errBase !== 0) $display("FAIL lock_no_err: got %0d pulses expected 0", errSeen - errBase); else passCnt++;
        totalCnt++; if (err_cnt !== 8'd0) $display("FAIL lock_errcnt: got %0d expected 0", err_cnt); else passCnt++;
        totalCnt++; if (R !== 4'b1000) $display("FAIL lock_R: got %b expected 1000", R); else passCnt++;
    endtask

    task automatic test_hold();
        errBase = errSeen;
        repeat (3) step(1'b0, ~predict(C, rModel));
        totalCnt++; if (R !== 4'b1000) $display("FAIL hold_R: got %b expected 1000", R); else passCnt++;
        totalCnt++; if (lock !== 1'b1) $display("FAIL hold_lock: got %b expected 1", lock); else passCnt++;
        totalCnt++; if (errSeen - errBase !== 0) $display("FAIL hold_err: got %0d pulses expected 0", errSeen - errBase); else passCnt++;
    endtask

    task automatic test_single_err();
        sendBad();
        totalCnt++; if (lastErr !== 1'b1) $display("FAIL single_err_pulse: got %b expected 1", lastErr); else passCnt++;
        totalCnt++; if (lock !== 1'b1) $display("FAIL single_err_lock: got %b expected 1", lock); else passCnt++;
        totalCnt++; if (err_cnt !== expCnt(1)) $display("FAIL single_err_cnt: got %0d expected %0d", err_cnt, expCnt(1)); else passCnt++;
        sendGood();
        totalCnt++; if (lastErr !== 1'b0) $display("FAIL single_err_next: got %b expected 0", lastErr); else passCnt++;
        totalCnt++; if (R !== rModel) $display("FAIL single_err_R: got %b expected %b", R, rModel); else passCnt++;
    endtask

    task automatic test_miss_clear();
        errBase = errSeen;
        sendBad(); sendBad(); sendGood(); sendBad(); sendBad(); sendGood();
        totalCnt++; if (lock !== 1'b1) $display("FAIL miss_clear_lock: got %b expected 1", lock); else passCnt++;
        totalCnt++; if (errSeen - errBase !== 4) $display("FAIL miss_clear_pulses: got %0d expected 4", errSeen - errBase); else passCnt++;
        totalCnt++; if (err_cnt !== expCnt(5)) $display("FAIL miss_clear_cnt: got %0d expected %0d", err_cnt, expCnt(5)); else passCnt++;
    endtask

    task automatic test_unlock3();
        errBase = errSeen;
        sendBad(); sendBad();
        totalCnt++; if (lock !== 1'b1) $display("FAIL unlock_after2: got %b expected 1", lock); else passCnt++;
        sendBad();
        totalCnt++; if (lastErr !== 1'b1) $display("FAIL unlock_3rd_pulse: got %b expected 1", lastErr); else passCnt++;
        totalCnt++; if (lock !== 1'b0) $display("FAIL unlock_after3: got %b expected 0", lock); else passCnt++;
        totalCnt++; if (err_cnt !== expCnt(8)) $display("FAIL unlock_cnt: got %0d expected %0d", err_cnt, expCnt(8)); else passCnt++;
        repeat (7) sendGood();
        totalCnt++; if (lock !== 1'b0) $display("FAIL relock_7: got %b expected 0", lock); else passCnt++;
        sendGood();
        totalCnt++; if (lock !== 1'b1) $display("FAIL relock_8: got %b expected 1", lock); else passCnt++;
        totalCnt++; if (errSeen - errBase !== 3) $display("FAIL unlock_pulses: got %0d expected 3", errSeen - errBase); else passCnt++;
    endtask

    task automatic test_cchange_valid();
        errBase = errSeen;
        C = 2'd3;
        sendGood();
        totalCnt++; if (lock !== 1'b0) $display("FAIL cchg_lock_drop: got %b expected 0", lock); else passCnt++;
        repeat (10) sendGood();
        totalCnt++; if (lock !== 1'b0) $display("FAIL cchg_lock_11: got %b expected 0", lock); else passCnt++;
        sendGood();
        totalCnt++; if (lock !== 1'b1) $display("FAIL cchg_lock_12: got %b expected 1", lock); else passCnt++;
        totalCnt++; if (errSeen - errBase !== 0) $display("FAIL cchg_no_err: got %0d pulses expected 0", errSeen - errBase); else passCnt++;
        totalCnt++; if (err_cnt !== expCnt(8)) $display("FAIL cchg_cnt_kept: got %0d expected %0d", err_cnt, expCnt(8)); else passCnt++;
        totalCnt++; if (R !== rModel) $display("FAIL cchg_R: got %b expected %b", R, rModel); else passCnt++;
    endtask

    task automatic test_cchange_idle();
        C = 2'd1;
        step(1'b0, 1'b0);
        totalCnt++; if (lock !== 1'b0) $display("FAIL cidle_lock_drop: got %b expected 0", lock); else passCnt++;
        totalCnt++; if (R !== rModel) $display("FAIL cidle_R_kept: got %b expected %b", R, rModel); else passCnt++;
        repeat (11) sendGood();
        totalCnt++; if (lock !== 1'b0) $display("FAIL cidle_lock_11: got %b expected 0", lock); else passCnt++;
        sendGood();
        totalCnt++; if (lock !== 1'b1) $display("FAIL cidle_lock_12: got %b expected 1", lock); else passCnt++;
    endtask

    task automatic test_saturate();
        errBase = errSeen;
        for (int k = 0; k < 300; k++) begin
            sendBad(); sendGood(); sendGood();
            if (k == 245) begin
                totalCnt++; if (err_cnt !== expCnt(254)) $display("FAIL sat_254: got %0d expected %0d", err_cnt, expCnt(254)); else passCnt++;
            end
        end
        totalCnt++; if (err_cnt !== expCnt(255)) $display("FAIL sat_255: got %0d expected %0d", err_cnt, expCnt(255)); else passCnt++;
        totalCnt++; if (lock !== 1'b1) $display("FAIL sat_lock: got %b expected 1", lock); else passCnt++;
        totalCnt++; if (errSeen - errBase !== 300) $display("FAIL sat_pulses: got %0d expected 300", errSeen - errBase); else passCnt++;
    endtask

    task automatic test_async_reset();
        totalCnt++; if (lock !== 1'b1) $display("FAIL areset_pre_lock: got %b expected 1", lock); else passCnt++;
        din_valid = 1'b1;
        din = ~predict(C, rModel);
        #1;
        totalCnt++; if (err !== 1'b1) $display("FAIL areset_pre_err: got %b expected 1", err); else passCnt++;
        #2;
        rst = 1'b1;
        #1;
        totalCnt++; if (lock !== 1'b0) $display("FAIL areset_lock: got %b expected 0", lock); else passCnt++;
        totalCnt++; if (err !== 1'b0) $display("FAIL areset_err: got %b expected 0", err); else passCnt++;
        totalCnt++; if (err_cnt !== 8'd0) $display("FAIL areset_cnt: got %0d expected 0", err_cnt); else passCnt++;
        totalCnt++; if (R !== 4'b0000) $display("FAIL areset_R: got %b expected 0000", R); else passCnt++;
        din_valid = 1'b0;
        @(negedge clk);
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        totalCnt++; if (R !== 4'b0000) $display("FAIL areset_R_held: got %b expected 0000", R); else passCnt++;
        rst = 1'b0;
        rModel = 4'b0000;
        repeat (11) sendGood();
        totalCnt++; if (lock !== 1'b0) $display("FAIL areset_relock_11: got %b expected 0", lock); else passCnt++;
        sendGood();
        totalCnt++; if (lock !== 1'b1) $display("FAIL areset_relock_12: got %b expected 1", lock); else passCnt++;
        totalCnt++; if (err_cnt !== 8'd0) $display("FAIL areset_relock_cnt: got %0d expected 0", err_cnt); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hold();
        test_single_err();
        test_miss_clear();
        test_unlock3();
        test_cchange_valid();
        test_cchange_idle();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire
